seg_scan_ctrl: RTL

Time-multiplexed scan controller that shares one 4-to-7 segment decoder between DIGITS display digits. It holds a 4-bit value per digit and steps a one-hot digit enable through the digits at a programmable slot rate. For each slot it routes the selected nibble to the shared decoder and registers the returned segment pattern. It sits between the processor's output-port register file and the board's multiplexed 7-segment display.

---
 rtl/seg_scan_pkg.sv | 16 +
 rtl/slot_timer.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and helpers for the segment scan controller
package seg_scan_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int MAX_DIGITS = 8;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] i);
    return MAX_DIGITS'(1) << i;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-slot prescale counter with slot start and phase strobes
module slot_timer #(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic running,
  output logic blank_last,
  output logic slot_last,
  output logic slot_start
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;

  assign slot_last  = (cnt == CW'(PRESCALE - 1));
  assign blank_last = (cnt == CW'(BLANK_CYC - 1));

  // A fresh slot begins either when leaving OFF or when the current slot wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      slot_start <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      slot_start <= 1'b0;
    end else if (!running || slot_last) begin
      cnt        <= '0;
      slot_start <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      slot_start <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller sharing one decoder
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      wr_en,
  input  logic [$clog2(DIGITS)-1:0] wr_addr,
  input  logic [3:0]                wr_data,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic [DIGITS-1:0]         blank_in,
  output logic [3:0]                dec_in,
  input  logic [6:0]                dec_out,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [DIGITS-1:0]         an,
  output logic                      slot_start
);

  localparam int AW = $clog2(DIGITS);

  state_t          state;
  logic [AW-1:0]   idx;
  logic [3:0]      digit [DIGITS];
  logic            blank_last;
  logic            slot_last;
  logic [3:0]      sel_nib;
  logic            sel_dp;
  logic            sel_blank;
  logic [DIGITS-1:0] an_show;

  slot_timer #(
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .running    (state != OFF),
    .blank_last (blank_last),
    .slot_last  (slot_last),
    .slot_start (slot_start)
  );

  // Explicit mux keeps idx values beyond DIGITS-1 harmless for non power-of-two counts.
  always_comb begin
    sel_nib   = 4'd0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == AW'(i)) begin
        sel_nib   = digit[i];
        sel_dp    = dp_in[i];
        sel_blank = blank_in[i];
      end
    end
    an_show = sel_blank ? '0 : DIGITS'(onehot(3'(idx)));
  end

  assign dec_in = sel_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      idx   <= '0;
      an    <= '0;
    end else if (!en) begin
      state <= OFF;
      idx   <= '0;
      an    <= '0;
    end else begin
      case (state)
        OFF: begin
          state <= BLANK;
          idx   <= '0;
          an    <= '0;
        end
        BLANK: begin
          if (blank_last) begin
            state <= SHOW;
            an    <= an_show;
          end else begin
            an <= '0;
          end
        end
        SHOW: begin
          if (slot_last) begin
            state <= BLANK;
            an    <= '0;
            idx   <= (idx == AW'(DIGITS - 1)) ? '0 : idx + 1'b1;
          end else begin
            an <= an_show;
          end
        end
        default: begin
          state <= OFF;
          an    <= '0;
        end
      endcase
    end
  end

  // Writes are honoured in every state; addresses with no matching digit fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) digit[i] <= 4'd0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en && wr_addr == AW'(i)) digit[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'd0;
      dp  <= 1'b0;
    end else begin
      seg <= dec_out;
      dp  <= sel_dp;
    end
  end

endmodule
